// File: rtl/hazard_scoreboard.sv
// Hazard unit with load-use detection plus a scoreboard of in-flight long-latency writes.
// Optional saturating stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_scoreboard #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned TAG_W       = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic [4:0]       opcode_i,
    input  logic             funct3_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             long_op_i,
    input  logic [4:0]       rd_EX_i,
    input  logic             load_EX_i,
    input  logic             flush_i,
    input  logic             cpl_valid_i,
    input  logic [TAG_W-1:0] cpl_tag_i,
    output logic             hazard_stall_o,
    output logic             alloc_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    output logic             full_o,
    output logic [TAG_W:0]   pending_o,
    output logic [CNT_W-1:0] stall_count_o
);

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;
    logic [NUM_ENTRIES-1:0] live;
    logic [4:0]             rd_q [NUM_ENTRIES];

    logic             uses_rs1;
    logic             uses_rs2;
    logic             load_use;
    logic             raw;
    logic             waw;
    logic             no_free;
    logic             stall;
    logic             alloc;
    logic [TAG_W-1:0] free_idx;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode_i)
            5'b11000, 5'b01000, 5'b01100: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            5'b11001, 5'b00000, 5'b00100: uses_rs1 = 1'b1;
            5'b11100:                     uses_rs1 = !funct3_i;
            default:                      ;
        endcase
    end

    // A completing entry is not live (writeback is forwarded) but is still not free.
    always_comb begin
        live     = '0;
        raw      = 1'b0;
        waw      = 1'b0;
        no_free  = 1'b1;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            live[i] = valid_q[i] && !(cpl_valid_i && (cpl_tag_i == TAG_W'(i)));
            if (!valid_q[i]) begin
                no_free  = 1'b0;
                free_idx = TAG_W'(i);
            end
            if (live[i]) begin
                if ((uses_rs1 && (rs1_i != 5'd0) && (rs1_i == rd_q[i])) ||
                    (uses_rs2 && (rs2_i != 5'd0) && (rs2_i == rd_q[i]))) begin
                    raw = 1'b1;
                end
                if (long_op_i && (rd_i != 5'd0) && (rd_i == rd_q[i])) begin
                    waw = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load_use = load_EX_i && (rd_EX_i != 5'd0) &&
                   ((uses_rs1 && (rs1_i == rd_EX_i)) || (uses_rs2 && (rs2_i == rd_EX_i)));
        stall    = id_valid_i && !flush_i &&
                   (load_use || raw || waw || (long_op_i && no_free));
        alloc    = id_valid_i && long_op_i && !flush_i && !stall && (rd_i != 5'd0);
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cpl_valid_i && (cpl_tag_i == TAG_W'(i))) valid_d[i] = 1'b0;
            if (alloc && (free_idx == TAG_W'(i)))        valid_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc && (free_idx == TAG_W'(i))) rd_q[i] <= rd_i;
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            pending_o = pending_o + {{TAG_W{1'b0}}, valid_q[i]};
        end
    end

    assign full_o         = &valid_q;
    assign hazard_stall_o = stall;
    assign alloc_o        = alloc;
    assign alloc_tag_o    = alloc ? free_idx : '0;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count_o = stall_cnt_q;
`else
    assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard; the reference model keeps pending
// writes in an associative array keyed by tag and applies the hazard rules directly.
module tb_hazard_scoreboard;

    localparam int unsigned N = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        id_valid_i;
    logic [4:0]  opcode_i;
    logic        funct3_i;
    logic [4:0]  rs1_i, rs2_i, rd_i;
    logic        long_op_i;
    logic [4:0]  rd_EX_i;
    logic        load_EX_i;
    logic        flush_i;
    logic        cpl_valid_i;
    logic [1:0]  cpl_tag_i;
    logic        hazard_stall_o;
    logic        alloc_o;
    logic [1:0]  alloc_tag_o;
    logic        full_o;
    logic [2:0]  pending_o;
    logic [31:0] stall_count_o;

    hazard_scoreboard dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .id_valid_i     (id_valid_i),
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rd_i           (rd_i),
        .long_op_i      (long_op_i),
        .rd_EX_i        (rd_EX_i),
        .load_EX_i      (load_EX_i),
        .flush_i        (flush_i),
        .cpl_valid_i    (cpl_valid_i),
        .cpl_tag_i      (cpl_tag_i),
        .hazard_stall_o (hazard_stall_o),
        .alloc_o        (alloc_o),
        .alloc_tag_o    (alloc_tag_o),
        .full_o         (full_o),
        .pending_o      (pending_o),
        .stall_count_o  (stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned pend [int unsigned];   // tag -> destination register
    longint unsigned model_cnt;
    int n_checks;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit reads_rs1(input logic [4:0] op, input logic f3);
        return (op == 5'b11000) || (op == 5'b11001) || (op == 5'b00000) || (op == 5'b01000) ||
               (op == 5'b00100) || (op == 5'b01100) || ((op == 5'b11100) && !f3);
    endfunction

    function automatic bit reads_rs2(input logic [4:0] op);
        return (op == 5'b11000) || (op == 5'b01000) || (op == 5'b01100);
    endfunction

    task automatic idle();
        id_valid_i = 0; opcode_i = 5'b01101; funct3_i = 0;
        rs1_i = 0; rs2_i = 0; rd_i = 0; long_op_i = 0;
        rd_EX_i = 0; load_EX_i = 0; flush_i = 0;
        cpl_valid_i = 0; cpl_tag_i = 0; reset_i = 0;
    endtask

    task automatic instr(input logic [4:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic lng);
        id_valid_i = 1; opcode_i = op; funct3_i = 0;
        rs1_i = s1; rs2_i = s2; rd_i = d; long_op_i = lng;
    endtask

    // Check all outputs against the model for the current inputs, then advance one cycle.
    task automatic step(input string tag);
        bit u1, u2, hit, e_stall, e_alloc;
        int unsigned e_tag;
        #1;
        u1  = reads_rs1(opcode_i, funct3_i);
        u2  = reads_rs2(opcode_i);
        hit = load_EX_i && rd_EX_i != 0 &&
              ((u1 && rs1_i == rd_EX_i) || (u2 && rs2_i == rd_EX_i));
        foreach (pend[t]) begin
            if (cpl_valid_i && cpl_tag_i == t) continue;
            if (u1 && rs1_i != 0 && rs1_i == pend[t]) hit = 1;
            if (u2 && rs2_i != 0 && rs2_i == pend[t]) hit = 1;
            if (long_op_i && rd_i != 0 && rd_i == pend[t]) hit = 1;
        end
        if (long_op_i && pend.num() == N) hit = 1;
        e_stall = id_valid_i && !flush_i && hit;
        e_alloc = id_valid_i && long_op_i && !flush_i && !e_stall && rd_i != 0;
        e_tag = 0;
        if (e_alloc) begin
            for (int t = N - 1; t >= 0; t--) if (!pend.exists(t)) e_tag = t;
        end
        chk({tag, ".stall"},   32'(hazard_stall_o), 32'(e_stall));
        chk({tag, ".alloc"},   32'(alloc_o),        32'(e_alloc));
        chk({tag, ".tag"},     32'(alloc_tag_o),    e_tag);
        chk({tag, ".pending"}, 32'(pending_o),      pend.num());
        chk({tag, ".full"},    32'(full_o),         32'(pend.num() == N));
`ifdef HAZARD_STALL_CNT_EN
        chk({tag, ".count"},   stall_count_o,       32'(model_cnt));
`else
        chk({tag, ".count"},   stall_count_o,       32'd0);
`endif
        if (reset_i) begin
            pend.delete();
            model_cnt = 0;
        end else begin
            if (cpl_valid_i && pend.exists(cpl_tag_i)) pend.delete(cpl_tag_i);
            if (e_alloc) pend[e_tag] = rd_i;
            if (e_stall && model_cnt != 64'hFFFF_FFFF) model_cnt++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; model_cnt = 0;
        idle();
        reset_i = 1;
        @(negedge clk_i);
        step("reset");
        idle();
        step("post_reset");

        // Load-use
        instr(5'b01100, 5, 1, 8, 0); load_EX_i = 1; rd_EX_i = 5;
        #1 chk("lu_hit", 32'(hazard_stall_o), 1);
        step("lu_hit");
        instr(5'b01100, 0, 1, 8, 0); rd_EX_i = 0;
        #1 chk("lu_x0", 32'(hazard_stall_o), 0);
        step("lu_x0");
        idle();

        // Long op tracking and same-cycle release
        instr(5'b00000, 1, 0, 7, 1);
        #1 chk("ld_alloc", 32'(alloc_o), 1);
        step("ld_alloc");
        instr(5'b01100, 1, 7, 9, 0);
        #1 chk("raw_pend", 32'(pending_o), 1);
        step("raw_wait0");
        #1 chk("raw_stall", 32'(hazard_stall_o), 1);
        step("raw_wait1");
        cpl_valid_i = 1; cpl_tag_i = 0;
        #1 chk("raw_release", 32'(hazard_stall_o), 0);
        step("raw_release");
        idle();
        #1 chk("raw_drained", 32'(pending_o), 0);
        step("raw_drained");

        // Full table and structural stall
        for (int r = 1; r <= 4; r++) begin
            instr(5'b00000, 0, 0, 5'(r), 1);
            step("fill");
        end
        instr(5'b00000, 0, 0, 9, 1);
        #1 chk("full", 32'(full_o), 1);
        step("struct0");
        cpl_valid_i = 1; cpl_tag_i = 2;
        #1 chk("struct_cpl", 32'(hazard_stall_o), 1);
        step("struct_cpl");
        cpl_valid_i = 0;
        #1 chk("struct_tag", 32'(alloc_tag_o), 2);
        step("struct_admit");
        idle();
        for (int t = 0; t < 4; t++) begin
            cpl_valid_i = 1; cpl_tag_i = 2'(t);
            step("drain");
        end
        idle();

        // WAW with no source use
        instr(5'b00000, 0, 0, 3, 1);
        step("waw_alloc");
        instr(5'b01101, 3, 3, 3, 1);
        #1 chk("waw_stall", 32'(hazard_stall_o), 1);
        step("waw0");
        step("waw1");
        cpl_valid_i = 1; cpl_tag_i = 0;
        step("waw_release");
        idle();
        cpl_valid_i = 1; cpl_tag_i = 1;
        step("waw_drain");
        idle();

        // Flush and reset
        instr(5'b01100, 5, 0, 6, 1); load_EX_i = 1; rd_EX_i = 5; flush_i = 1;
        #1 chk("flush_alloc", 32'(alloc_o), 0);
        step("flush");
        idle();
        for (int r = 1; r <= 3; r++) begin
            instr(5'b00000, 0, 0, 5'(10 + r), 1);
            step("pre_reset");
        end
        idle();
        reset_i = 1;
        step("mid_reset");
        idle();
        cpl_valid_i = 1; cpl_tag_i = 1;
        step("stale_cpl");
        idle();
        #1 chk("stale_pend", 32'(pending_o), 0);
        step("stale_after");

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            logic [4:0] ops [9] = '{5'b11000, 5'b11001, 5'b00000, 5'b01000, 5'b00100,
                                    5'b01100, 5'b11100, 5'b01101, 5'b11011};
            idle();
            id_valid_i  = ($urandom_range(0, 9) != 0);
            opcode_i    = ops[$urandom_range(0, 8)];
            funct3_i    = 1'($urandom);
            rs1_i       = 5'($urandom_range(0, 7));
            rs2_i       = 5'($urandom_range(0, 7));
            rd_i        = 5'($urandom_range(0, 7));
            long_op_i   = ($urandom_range(0, 2) == 0);
            load_EX_i   = 1'($urandom);
            rd_EX_i     = 5'($urandom_range(0, 7));
            flush_i     = ($urandom_range(0, 15) == 0);
            cpl_valid_i = ($urandom_range(0, 2) == 0);
            cpl_tag_i   = 2'($urandom);
            reset_i     = ($urandom_range(0, 199) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
